dmem_bus_ctrl: RTL
==================

Name: dmem_bus_ctrl

Overview:
- Sits directly downstream of the memory stage. It consumes that stage's dmem request (addr, ren, wen, wdata, mask) and returns read data to it.
- Converts the single-cycle request into a req/gnt + rvalid handshake toward a variable-latency data memory or bus.
- Stalls the pipeline until each access completes.
- Guarantees exactly one bus transaction per memory instruction, even when the pipeline is frozen by other causes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in REQ+WAIT before a fault is forced (used only with DMEM_TIMEOUT_EN).
- RDATA_RST, 32'h0000_0000: reset and fault value of o_dmem_rdata.

Ports:
- i_clk  in  1  clock. The block uses one clock; reset is asynchronous and active-low.
- i_rst  in  1  reset, asynchronous, active-low (0 = reset).
- i_dmem_addr  in  32  word-aligned address from the memory stage.
- i_dmem_ren  in  1  load request.
- i_dmem_wen  in  1  store request.
- i_dmem_wdata  in  32  pre-shifted store data.
- i_dmem_mask  in  4  byte-enable mask.
- o_dmem_rdata  out  32  captured load word returned to the memory stage.
- i_hold  in  1  pipeline frozen by another source; the current instruction does not advance.
- o_stall  out  1  pipeline stall request from this block.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  registered address.
- o_bus_wdata  out  32  registered write data.
- o_bus_mask  out  4  registered mask.
- i_bus_gnt  in  1  request accepted this cycle.
- i_bus_rvalid  in  1  read data valid.
- i_bus_rdata  in  32  read data.
- o_dmem_fault  out  1  one-cycle timeout pulse; constant 0 without the macro.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. 2-bit encoding, registered.
- Reset (i_rst=0, asynchronous):
  - state=IDLE.
  - o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_bus_mask=0.
  - o_dmem_rdata=RDATA_RST, o_dmem_fault=0, timeout counter=0.
- IDLE:
  - If ren|wen: o_stall=1 (combinational, same cycle). Latch addr, wdata and mask into the o_bus_* registers. o_bus_we=wen (wen wins if both are set). Next state REQ.
  - Otherwise o_stall=0.
- REQ:
  - o_bus_req=1, o_stall=1.
  - On i_bus_gnt: a write goes to DONE; a read goes to WAIT. o_bus_req drops the following cycle.
  - Request fields stay stable until gnt.
- WAIT:
  - o_stall=1.
  - On i_bus_rvalid: o_dmem_rdata<=i_bus_rdata, next state DONE.
  - rvalid is sampled only in WAIT. The earliest legal rvalid is the cycle after gnt.
- DONE:
  - o_stall=0. The instruction advances unless i_hold is set.
  - If i_hold=1, stay in DONE. No reissue; rdata stays stable.
  - Otherwise go to IDLE.
- o_dmem_rdata holds its last captured value in all other states.
- Latency with gnt and rvalid at the earliest opportunity:
  - Load: stall for 3 cycles; data is valid in DONE, the 4th cycle.
  - Store: stall for 2 cycles.
- i_bus_rvalid outside WAIT is ignored. This includes a stale response arriving after reset.
- Reset mid-transaction aborts to IDLE. A bus response already in flight is ignored.
- Address, wdata and mask changes while in REQ/WAIT/DONE are ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, force DONE, drop o_bus_req, set o_dmem_rdata=RDATA_RST and pulse o_dmem_fault for one cycle (the DONE entry cycle).
- Disabled: no counter; o_dmem_fault is tied to 0; the block waits indefinitely.

Decomposition:
- Shared header dmem_defs.vh holds:
  - the state encodings (ST_IDLE=2'd0, ST_REQ=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3);
  - the RDATA_RST default.
- One natural sub-module, dmem_timeout_ctr: counter plus expiry compare, instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Load, zero-wait: ren=1, addr=32'h100; gnt in REQ; rvalid next cycle with rdata=32'hCAFE_F00D.
  - Required: o_stall high for exactly 3 cycles; o_bus_addr=32'h100 and o_bus_we=0 during REQ; o_dmem_rdata=32'hCAFE_F00D in DONE.
- Store with gnt delayed 4 cycles: wen=1, wdata=32'h1234_5678, mask=4'b0011.
  - Required: o_bus_req high for 5 cycles with fields stable; o_bus_we=1; o_stall drops in DONE; exactly one gnt-accepted transfer.
- i_hold=1 for 3 cycles in DONE after a load.
  - Required: state stays DONE; o_bus_req stays 0 (no reissue); o_dmem_rdata stays stable.
- Asynchronous reset asserted in WAIT, then a stale rvalid with rdata=32'hFFFF_FFFF.
  - Required: immediate IDLE; o_bus_req=0; o_dmem_rdata stays 0; rvalid ignored.
- Back-to-back: a load followed immediately by a store.
  - Required: two separate transactions; IDLE entered between them; the store issues only after DONE→IDLE.
- DMEM_TIMEOUT_EN with TIMEOUT_CYCLES=8: read granted, no rvalid ever.
  - Required: DONE entered 8 cycles after REQ entry; o_dmem_fault is a one-cycle pulse; o_dmem_rdata=0; o_stall released.

Source files
------------

// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared types and defaults for the dmem bus controller.
// No logic lives here.
// There is no backpressure in this file.
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] RDATA_RST_DFLT = 32'h0000_0000;

endpackage

// File: rtl/dmem_bus_ctrl_if.sv
// Bus interface between the controller and a variable-latency data memory.
// Latency: none, this file only declares wires.
// Backpressure: req is held until gnt; the load response comes later on rvalid.
interface dmem_bus_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_mask,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/dmem_bus_ctrl_timeout_ctr.sv
// Counts the cycles spent in REQ or WAIT and flags the last cycle before the limit.
// Latency: expired is combinational from the count; the count is cleared when REQ is entered.
// Backpressure: none; the counter only observes the controller.
module dmem_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic busy,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + W'(1);
        end
    end

    // Raise expired one cycle early so that DONE is entered exactly LIMIT cycles after REQ.
    assign expired = busy && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Turns a single-cycle memory-stage request into one req/gnt + rvalid bus transaction.
// Latency: a load stalls for 3 cycles and a store for 2 when the bus answers as early as it can.
// Backpressure: o_stall is held until DONE; i_hold parks the block in DONE. Define DMEM_TIMEOUT_EN to enable the timeout.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RDATA_RST = RDATA_RST_DFLT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_dmem_addr,
    input  logic                  i_dmem_ren,
    input  logic                  i_dmem_wen,
    input  logic [31:0]           i_dmem_wdata,
    input  logic [3:0]            i_dmem_mask,
    output logic [31:0]           o_dmem_rdata,
    input  logic                  i_hold,
    output logic                  o_stall,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [31:0]           o_bus_addr,
    output logic [31:0]           o_bus_wdata,
    output logic [3:0]            o_bus_mask,
    input  logic                  i_bus_gnt,
    input  logic                  i_bus_rvalid,
    input  logic [31:0]           i_bus_rdata,
    output logic                  o_dmem_fault
);

    state_t state;
    state_t state_nxt;
    logic   start;
    logic   fault_hit;

    assign start = i_dmem_ren | i_dmem_wen;

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rst),
        .clr     ((state == ST_IDLE) && start),
        .busy    ((state == ST_REQ) || (state == ST_WAIT)),
        .expired (fault_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_dmem_fault <= 1'b0;
        end else begin
            o_dmem_fault <= fault_hit;
        end
    end
`else
    assign fault_hit    = 1'b0;
    assign o_dmem_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    o_stall   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                o_stall = 1'b1;
                if (i_bus_gnt) begin
                    state_nxt = o_bus_we ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_bus_rvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!i_hold) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A timeout overrides any response that arrives in the same cycle.
        if (fault_hit) begin
            state_nxt = ST_DONE;
        end
    end

    assign o_bus_req = (state == ST_REQ);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_bus_mask   <= '0;
            o_dmem_rdata <= RDATA_RST;
        end else begin
            if ((state == ST_IDLE) && start) begin
                o_bus_we    <= i_dmem_wen;
                o_bus_addr  <= i_dmem_addr;
                o_bus_wdata <= i_dmem_wdata;
                o_bus_mask  <= i_dmem_mask;
            end
            if (fault_hit) begin
                o_dmem_rdata <= RDATA_RST;
            end else if ((state == ST_WAIT) && i_bus_rvalid) begin
                o_dmem_rdata <= i_bus_rdata;
            end
        end
    end

endmodule
